// File: rtl/withdraw_pkg.sv
// Shared types and constants for the withdrawal controller.
// Holds the FSM state encoding, amount lookup and default parameter values.
package withdraw_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam logic [7:0] AMT_10  = 8'd10;
    localparam logic [7:0] AMT_20  = 8'd20;
    localparam logic [7:0] AMT_50  = 8'd50;
    localparam logic [7:0] AMT_100 = 8'd100;

    localparam int unsigned DEP_UNIT_DEF    = 10;
    localparam int unsigned MAX_BAL_DEF     = 4095;
    localparam int unsigned ACK_TIMEOUT_DEF = 200;

    function automatic logic [7:0] amt_lookup(input logic [1:0] sel);
        logic [7:0] amt;
        case (sel)
            2'd0:    amt = AMT_10;
            2'd1:    amt = AMT_20;
            2'd2:    amt = AMT_50;
            default: amt = AMT_100;
        endcase
        return amt;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a synchronous level input.
// A level already high when reset releases must go low before it can fire.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic pulse_o
);

    logic prev_q;
    logic armed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q <= level_i;
            if (!level_i) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign pulse_o = level_i & ~prev_q & armed_q;

endmodule

// File: rtl/withdraw_ctrl.sv
// Withdrawal controller: balance keeping, dispenser handshake with ack timeout.
// Deposits are accepted in every state and merge with a commit in the same cycle.
module withdraw_ctrl
    import withdraw_pkg::*;
#(
    parameter int unsigned DEP_UNIT    = DEP_UNIT_DEF,
    parameter int unsigned MAX_BAL     = MAX_BAL_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        down_button,
    input  logic        inc,
    input  logic [1:0]  amt_sel,
    input  logic        disp_ack,
    output logic [11:0] balance,
    output logic        disp_req,
    output logic [7:0]  disp_amt,
    output logic        dec,
    output logic        insuff,
    output logic        err,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [11:0] bal_q, bal_d;
    logic [7:0]  amt_q, amt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        disp_req_q, disp_req_d;
    logic        dec_q, dec_d;
    logic        insuff_q, insuff_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        req;
    logic        commit;
    logic [12:0] sum;

    btn_edge u_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (down_button),
        .pulse_o (req)
    );

    always_comb begin
        state_d  = state_q;
        amt_d    = amt_q;
        cnt_d    = cnt_q;
        commit   = 1'b0;
        insuff_d = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    amt_d   = amt_lookup(amt_sel);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (bal_q >= {4'b0000, amt_q}) begin
                    cnt_d   = '0;
                    state_d = WAIT_ACK;
                end else begin
                    insuff_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            WAIT_ACK: begin
                if (disp_ack) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Subtract first: CHECK guaranteed cover, so the difference cannot wrap.
        sum = {1'b0, bal_q};
        if (commit) begin
            sum = sum - {5'b00000, amt_q};
        end
        if (inc) begin
            sum = sum + 13'(DEP_UNIT);
        end
        if (sum > 13'(MAX_BAL)) begin
            sum = 13'(MAX_BAL);
        end
        bal_d = sum[11:0];

        disp_req_d = (state_d == WAIT_ACK);
        dec_d      = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bal_q      <= '0;
            amt_q      <= '0;
            cnt_q      <= '0;
            disp_req_q <= 1'b0;
            dec_q      <= 1'b0;
            insuff_q   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bal_q      <= bal_d;
            amt_q      <= amt_d;
            cnt_q      <= cnt_d;
            disp_req_q <= disp_req_d;
            dec_q      <= dec_d;
            insuff_q   <= insuff_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign balance  = bal_q;
    assign disp_req = disp_req_q;
    assign disp_amt = amt_q;
    assign dec      = dec_q;
    assign insuff   = insuff_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_withdraw_ctrl.sv
// Scoreboarded bench for withdraw_ctrl: expected dec/insuff/err events are
// queued when stimulus is driven and matched when the DUT pulses them.
module tb_withdraw_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        down_button = 1'b0;
    logic        inc = 1'b0;
    logic [1:0]  amt_sel = 2'd0;
    logic        disp_ack = 1'b0;
    logic [11:0] balance;
    logic        disp_req;
    logic [7:0]  disp_amt;
    logic        dec;
    logic        insuff;
    logic        err;
    logic        busy;

    typedef struct {
        logic [2:0]  kind;  // {err, insuff, dec}
        int unsigned amt;
        int unsigned bal;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned dec_cnt  = 0;
    int unsigned ins_cnt  = 0;
    int unsigned exp_bal  = 0;

    withdraw_ctrl #(.DEP_UNIT(10), .MAX_BAL(4095), .ACK_TIMEOUT(200)) dut (
        .clk         (clk),
        .rst         (rst),
        .down_button (down_button),
        .inc         (inc),
        .amt_sel     (amt_sel),
        .disp_ack    (disp_ack),
        .balance     (balance),
        .disp_req    (disp_req),
        .disp_amt    (disp_amt),
        .dec         (dec),
        .insuff      (insuff),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned lut(input logic [1:0] sel);
        case (sel)
            2'd0:    return 10;
            2'd1:    return 20;
            2'd2:    return 50;
            default: return 100;
        endcase
    endfunction

    function automatic int unsigned sat(input int unsigned v);
        return (v > 4095) ? 4095 : v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (dec || insuff || err)) begin
            if (dec) dec_cnt++;
            if (insuff) ins_cnt++;
            check("sb_avail", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_kind", {err, insuff, dec}, e.kind);
                check("sb_amt", disp_amt, e.amt);
                check("sb_bal", balance, e.bal);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        check("rst_bal", balance, 0);
        check("rst_req", disp_req, 0);
        check("rst_amt", disp_amt, 0);
        check("rst_pulses", {err, insuff, dec}, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        exp_bal = 0;
    endtask

    task automatic deposit(input int unsigned n);
        repeat (n) begin
            inc = 1'b1;
            tick;
            inc = 1'b0;
            exp_bal = sat(exp_bal + 10);
        end
        check("deposit_bal", balance, exp_bal);
    endtask

    // Leaves the bench in the cycle after the request edge (state CHECK).
    task automatic press(input logic [1:0] sel);
        amt_sel = sel;
        down_button = 1'b1;
        tick;
        down_button = 1'b0;
    endtask

    task automatic withdraw(input logic [1:0] sel, input int unsigned ack_dly, input bit with_inc);
        int unsigned amt;
        int unsigned nb;
        amt = lut(sel);
        press(sel);
        check("latch_amt", disp_amt, amt);
        check("busy_check", busy, 1);
        tick;
        check("req_latency", disp_req, 1);
        repeat (ack_dly) tick;
        disp_ack = 1'b1;
        inc = with_inc;
        nb = sat(exp_bal - amt + (with_inc ? 10 : 0));
        sb_q.push_back('{kind: 3'b001, amt: amt, bal: nb});
        exp_bal = nb;
        tick;
        disp_ack = 1'b0;
        inc = 1'b0;
        check("dec_pulse", dec, 1);
        check("commit_bal", balance, exp_bal);
        tick;
        check("back_idle", busy, 0);
        check("req_drop", disp_req, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned k;
        int unsigned d0;
        int unsigned i0;
        bit          seen_req;

        do_reset;

        // Three deposits, withdraw 20 with ack three cycles after disp_req.
        deposit(3);
        d0 = dec_cnt;
        withdraw(2'd1, 3, 1'b0);
        check("t1_bal", balance, 10);
        check("t1_dec_once", dec_cnt - d0, 1);
        check("t1_amt", disp_amt, 20);

        // Stray ack in IDLE must not start or commit anything.
        disp_ack = 1'b1;
        tick;
        disp_ack = 1'b0;
        tick;
        check("stray_ack_busy", busy, 0);
        check("stray_ack_bal", balance, 10);

        // Balance 40, ask for 50: refused, no dispense request.
        deposit(3);
        i0 = ins_cnt;
        sb_q.push_back('{kind: 3'b010, amt: 50, bal: 40});
        press(2'd2);
        seen_req = 1'b0;
        repeat (6) begin
            seen_req |= disp_req;
            tick;
        end
        check("insuff_no_req", seen_req, 0);
        check("insuff_once", ins_cnt - i0, 1);
        check("insuff_bal", balance, 40);

        // Balance 100, ask for 100 with no ack: timeout after 200 cycles.
        deposit(6);
        sb_q.push_back('{kind: 3'b100, amt: 100, bal: 100});
        press(2'd3);
        tick;
        check("to_req", disp_req, 1);
        n = 0;
        k = 0;
        while (!err && k < 400) begin
            if (disp_req) n++;
            k++;
            tick;
        end
        check("to_err_seen", err, 1);
        check("to_cycles", n, 200);
        check("to_idle", busy, 0);
        check("to_bal", balance, 100);

        // Withdraw 50 twice; the second commit coincides with a deposit.
        withdraw(2'd2, 1, 1'b0);
        check("w50_bal", balance, 50);
        withdraw(2'd2, 0, 1'b1);
        check("merge_bal", balance, 10);

        // Saturation at the ceiling.
        deposit(408);
        check("near_max", balance, 4090);
        deposit(1);
        check("sat_1", balance, 4095);
        deposit(1);
        check("sat_2", balance, 4095);

        // Button held 20 cycles, second press in WAIT_ACK: one withdrawal only.
        d0 = dec_cnt;
        amt_sel = 2'd0;
        down_button = 1'b1;
        tick;
        tick;
        check("hold_req", disp_req, 1);
        repeat (18) tick;
        down_button = 1'b0;
        tick;
        amt_sel = 2'd3;
        down_button = 1'b1;
        tick;
        down_button = 1'b0;
        tick;
        check("hold_amt", disp_amt, 10);
        check("hold_busy", busy, 1);
        disp_ack = 1'b1;
        sb_q.push_back('{kind: 3'b001, amt: 10, bal: 4085});
        exp_bal = 4085;
        tick;
        disp_ack = 1'b0;
        repeat (10) tick;
        check("hold_one_dec", dec_cnt - d0, 1);
        check("hold_bal", balance, 4085);
        check("hold_idle", busy, 0);

        // Reset while waiting for ack at balance 60.
        do_reset;
        deposit(6);
        d0 = dec_cnt;
        press(2'd0);
        tick;
        check("rw_req", disp_req, 1);
        tick;
        rst = 1'b1;
        down_button = 1'b1;
        tick;
        check("rw_req_drop", disp_req, 0);
        check("rw_bal", balance, 0);
        check("rw_no_dec", dec, 0);
        rst = 1'b0;
        exp_bal = 0;
        repeat (5) tick;
        check("held_no_req", busy, 0);
        check("rw_dec_cnt", dec_cnt - d0, 0);
        down_button = 1'b0;
        tick;
        sb_q.push_back('{kind: 3'b010, amt: 10, bal: 0});
        press(2'd0);
        check("repress_busy", busy, 1);
        repeat (4) tick;
        check("repress_idle", busy, 0);

        check("sb_drain", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
